captura_requisicao: RTL and testbench
=====================================

# captura_requisicao

Upstream input stage for the two-terminal access controller. For each terminal it synchronizes the user ID/function switches, debounces a confirm pushbutton, and latches one request on each confirmed press. It holds the latched request for a fixed display window, then clears it. Its registered outputs drive the combinational authentication/functionality/display path directly: HH0/HH1 carry the user ID, B0/B1 the function select, and VALID0/VALID1 mark a live request.

## Interface
- DEBOUNCE_CYCLES, 250000: consecutive stable cycles required before a button level is accepted (5 ms @ 50 MHz).
- HOLD_CYCLES, 250000000: cycles a latched request stays valid (5 s @ 50 MHz).
- clk  in  1  single system clock; all logic on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- SW0  in  6  terminal 0 raw switches: [3:0] user ID, [5:4] function select.
- SW1  in  6  terminal 1 raw switches, same layout.
- BTN0, BTN1  in  1 each  raw confirm keys, active-low (0 = pressed).
- BTN_CLR  in  1  raw global clear key, active-low, not debounced.
- HH0, HH1  out  4 each  latched user ID per terminal.
- B0, B1  out  2 each  latched function select per terminal.
- VALID0, VALID1  out  1 each  high while the terminal holds a live request.

## Operation
- Every raw input passes through a 2-flop synchronizer before use; the switches are sampled only from their synchronized copies.
- Debounce (per confirm key): a counter runs while the synchronized level differs from the accepted level. It resets to 0 whenever the level matches, or whenever the raw level toggles back. The accepted level flips when the counter reaches DEBOUNCE_CYCLES-1. The accepted level resets to "released".
- Press event: the accepted level transitions released→pressed. This is a single-cycle pulse.
- Per-terminal FSM, states IDLE, HOLD, WAIT_REL:
  - IDLE: outputs HH=0, B=0, VALID=0. A press event latches the synchronized SW into HH/B, loads the hold counter with HOLD_CYCLES-1, and moves to HOLD.
  - HOLD: VALID=1 and HH/B are frozen; the counter decrements each cycle.
    - A press event re-latches SW and reloads the counter (restarts the window), staying in HOLD.
    - When the counter reaches 0: go to IDLE if the key is released, else go to WAIT_REL.
  - WAIT_REL: VALID=0, HH/B=0. Move to IDLE when the accepted level is released. No new request is taken until after the release.
- Clear: a synchronized BTN_CLR low forces both FSMs to IDLE with outputs zeroed on the next edge. Clear beats a simultaneous press event, and the press is discarded.
- Switch changes during HOLD are ignored.
- Terminals are fully independent apart from clear; simultaneous presses on both are both accepted.
- Reset: every state goes to IDLE, all outputs go to 0, counters to 0, synchronizers to "released" (1) for the keys and 0 for the switches. A reset mid-HOLD drops the request.

## Timing
- All outputs are registered.
- Key press: raw key goes low and stays low from edge t. The synchronized level appears at t+2, the accepted level flips at t+2+DEBOUNCE_CYCLES, and VALID/HH/B update at t+3+DEBOUNCE_CYCLES.
- VALID stays high for exactly HOLD_CYCLES cycles after a single press.
- Clear: raw low at t gives outputs zero at t+3.
- A glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no press event.
- Counter widths are $clog2(param). HOLD_CYCLES ≥ 1 and DEBOUNCE_CYCLES ≥ 1 are enforced by elaboration assertions.

## Structure
- Package captura_pkg holds:
  - the FSM enum (IDLE, HOLD, WAIT_REL), 2-bit;
  - the SW field localparams (ID_LSB=0, ID_W=4, FN_LSB=4, FN_W=2).
- Sub-module `debounce` contains the synchronizer, counter, accepted level, and press pulse. It is instantiated once per confirm key.
- The FSM and latch are replicated inline per terminal. The clear synchronizer lives in the top level.

## Test plan
Parameters for the bench: DEBOUNCE_CYCLES=4, HOLD_CYCLES=10.
- Reset: rst_n=0 for 3 cycles with arbitrary inputs → all outputs 0; after release, with no press, outputs stay 0.
- Basic capture: SW0=6'b10_0101, BTN0 low at t and held → at t+7 HH0=4'h5, B0=2'b10, VALID0=1; VALID0 stays high 10 cycles; then since the key is held, WAIT_REL with outputs 0; after the key is released and debounced → IDLE.
- Glitch reject: BTN1 low for 3 cycles, then high → VALID1 never asserts.
- Re-press restart: during HOLD, change SW0 to 6'b01_0011, release and re-press → outputs become HH0=3, B0=1 and VALID0 is extended by 10 cycles from the new latch.
- Clear priority: both terminals in HOLD, BTN_CLR low for 1 cycle coinciding with a new BTN1 press event → both VALID=0 three cycles later, and the press is not latched.
- Reset mid-operation: rst_n=0 during HOLD on terminal 0 → outputs 0 on the next edge; after release the bench requires a fresh press to re-validate.

Source files
------------

// File: rtl/captura_pkg.sv
// Shared types and switch field layout for the two-terminal request capture stage.
package captura_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      HOLD     = 2'd1,
      WAIT_REL = 2'd2
   } estado_t;

   localparam int ID_LSB = 0;
   localparam int ID_W   = 4;
   localparam int FN_LSB = 4;
   localparam int FN_W   = 2;

   // Counter width able to hold p-1, never narrower than one bit.
   function automatic int cnt_w(input int p);
      return (p > 1) ? $clog2(p) : 1;
   endfunction

endpackage

// File: rtl/captura_requisicao_debounce.sv
// Confirm-key conditioning: 2-flop synchronizer, stability counter, accepted level and press pulse.
module debounce
   import captura_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic nivel,
   output logic press
);

   localparam int CW = cnt_w(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic          aceito;
   logic          aceito_d;
   logic [CW-1:0] cnt;

   // Keys are active-low, so every level register rests at 1 (released).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1    <= 1'b1;
         sync2    <= 1'b1;
         aceito   <= 1'b1;
         aceito_d <= 1'b1;
         cnt      <= '0;
      end else begin
         sync1    <= btn_raw;
         sync2    <= sync1;
         aceito_d <= aceito;
         if (sync2 == aceito) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            aceito <= sync2;
            cnt    <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign nivel = aceito;
   // One cycle high right after the accepted level falls to pressed.
   assign press = aceito_d & ~aceito;

endmodule

// File: rtl/captura_requisicao.sv
// Two-terminal request capture: synchronized switches, debounced confirm keys,
// per-terminal hold FSM with registered HH/B/VALID outputs and a global clear.
module captura_requisicao
   import captura_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int HOLD_CYCLES     = 250000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] SW0,
   input  logic [5:0] SW1,
   input  logic       BTN0,
   input  logic       BTN1,
   input  logic       BTN_CLR,
   output logic [3:0] HH0,
   output logic [3:0] HH1,
   output logic [1:0] B0,
   output logic [1:0] B1,
   output logic       VALID0,
   output logic       VALID1,
   output logic [1:0] state0,
   output logic [1:0] state1
);

   generate
      if (HOLD_CYCLES < 1) begin : g_chk_hold
         $error("HOLD_CYCLES must be at least 1");
      end
      if (DEBOUNCE_CYCLES < 1) begin : g_chk_deb
         $error("DEBOUNCE_CYCLES must be at least 1");
      end
   endgenerate

   localparam int HW = cnt_w(HOLD_CYCLES);
   localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);

   logic [5:0]    sw0_m, sw0_s;
   logic [5:0]    sw1_m, sw1_s;
   logic          clr_m, clr_s;
   logic          nivel0, press0;
   logic          nivel1, press1;
   estado_t       est0, est1;
   logic [HW-1:0] hold0, hold1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sw0_m <= '0;
         sw0_s <= '0;
         sw1_m <= '0;
         sw1_s <= '0;
         clr_m <= 1'b1;
         clr_s <= 1'b1;
      end else begin
         sw0_m <= SW0;
         sw0_s <= sw0_m;
         sw1_m <= SW1;
         sw1_s <= sw1_m;
         clr_m <= BTN_CLR;
         clr_s <= clr_m;
      end
   end

   debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb0 (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_raw (BTN0),
      .nivel   (nivel0),
      .press   (press0)
   );

   debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_raw (BTN1),
      .nivel   (nivel1),
      .press   (press1)
   );

   // Terminal 0. Clear shares the reset branch so it wins over a same-cycle press.
   always_ff @(posedge clk) begin
      if (!rst_n || !clr_s) begin
         est0   <= IDLE;
         HH0    <= '0;
         B0     <= '0;
         VALID0 <= 1'b0;
         hold0  <= '0;
      end else begin
         case (est0)
            IDLE: begin
               if (press0) begin
                  HH0    <= sw0_s[ID_LSB +: ID_W];
                  B0     <= sw0_s[FN_LSB +: FN_W];
                  VALID0 <= 1'b1;
                  hold0  <= HOLD_MAX;
                  est0   <= HOLD;
               end
            end
            HOLD: begin
               if (press0) begin
                  HH0   <= sw0_s[ID_LSB +: ID_W];
                  B0    <= sw0_s[FN_LSB +: FN_W];
                  hold0 <= HOLD_MAX;
               end else if (hold0 == '0) begin
                  HH0    <= '0;
                  B0     <= '0;
                  VALID0 <= 1'b0;
                  est0   <= nivel0 ? IDLE : WAIT_REL;
               end else begin
                  hold0 <= hold0 - 1'b1;
               end
            end
            WAIT_REL: begin
               if (nivel0) begin
                  est0 <= IDLE;
               end
            end
            default: begin
               est0   <= IDLE;
               HH0    <= '0;
               B0     <= '0;
               VALID0 <= 1'b0;
               hold0  <= '0;
            end
         endcase
      end
   end

   // Terminal 1, identical to terminal 0.
   always_ff @(posedge clk) begin
      if (!rst_n || !clr_s) begin
         est1   <= IDLE;
         HH1    <= '0;
         B1     <= '0;
         VALID1 <= 1'b0;
         hold1  <= '0;
      end else begin
         case (est1)
            IDLE: begin
               if (press1) begin
                  HH1    <= sw1_s[ID_LSB +: ID_W];
                  B1     <= sw1_s[FN_LSB +: FN_W];
                  VALID1 <= 1'b1;
                  hold1  <= HOLD_MAX;
                  est1   <= HOLD;
               end
            end
            HOLD: begin
               if (press1) begin
                  HH1   <= sw1_s[ID_LSB +: ID_W];
                  B1    <= sw1_s[FN_LSB +: FN_W];
                  hold1 <= HOLD_MAX;
               end else if (hold1 == '0) begin
                  HH1    <= '0;
                  B1     <= '0;
                  VALID1 <= 1'b0;
                  est1   <= nivel1 ? IDLE : WAIT_REL;
               end else begin
                  hold1 <= hold1 - 1'b1;
               end
            end
            WAIT_REL: begin
               if (nivel1) begin
                  est1 <= IDLE;
               end
            end
            default: begin
               est1   <= IDLE;
               HH1    <= '0;
               B1     <= '0;
               VALID1 <= 1'b0;
               hold1  <= '0;
            end
         endcase
      end
   end

   assign state0 = est0;
   assign state1 = est1;

endmodule

// File: tb/tb_captura_requisicao.sv
// Directed bench for captura_requisicao with DEBOUNCE_CYCLES=4, HOLD_CYCLES=10.
module tb_captura_requisicao;
   import captura_pkg::*;

   logic       clk;
   logic       rst_n;
   logic [5:0] SW0, SW1;
   logic       BTN0, BTN1, BTN_CLR;
   logic [3:0] HH0, HH1;
   logic [1:0] B0, B1;
   logic       VALID0, VALID1;
   logic [1:0] state0, state1;

   int checks   = 0;
   int failures = 0;

   captura_requisicao #(.DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .SW0     (SW0),
      .SW1     (SW1),
      .BTN0    (BTN0),
      .BTN1    (BTN1),
      .BTN_CLR (BTN_CLR),
      .HH0     (HH0),
      .HH1     (HH1),
      .B0      (B0),
      .B1      (B1),
      .VALID0  (VALID0),
      .VALID1  (VALID1),
      .state0  (state0),
      .state1  (state1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Advance n rising edges and land 1 time unit after the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset with arbitrary inputs
      rst_n = 1'b0; SW0 = 6'h3F; SW1 = 6'h2A; BTN0 = 1'b0; BTN1 = 1'b0; BTN_CLR = 1'b1;
      tick(3);
      chk("rst_hh0", 8'(HH0), 8'h0);
      chk("rst_b0", 8'(B0), 8'h0);
      chk("rst_valid0", 8'(VALID0), 8'h0);
      chk("rst_hh1", 8'(HH1), 8'h0);
      chk("rst_b1", 8'(B1), 8'h0);
      chk("rst_valid1", 8'(VALID1), 8'h0);
      BTN0 = 1'b1; BTN1 = 1'b1; rst_n = 1'b1;
      tick(8);
      chk("idle_valid0", 8'(VALID0), 8'h0);
      chk("idle_valid1", 8'(VALID1), 8'h0);
      chk("idle_state0", 8'(state0), 8'(IDLE));

      // Basic capture, key held through the window
      SW0 = 6'b10_0101; BTN0 = 1'b0;
      tick(6);
      chk("cap_valid0_early", 8'(VALID0), 8'h0);
      tick(1);
      chk("cap_hh0", 8'(HH0), 8'h5);
      chk("cap_b0", 8'(B0), 8'h2);
      chk("cap_valid0", 8'(VALID0), 8'h1);
      SW0 = 6'h3F;
      tick(9);
      chk("cap_valid0_last", 8'(VALID0), 8'h1);
      chk("cap_hh0_frozen", 8'(HH0), 8'h5);
      tick(1);
      chk("cap_valid0_end", 8'(VALID0), 8'h0);
      chk("cap_hh0_end", 8'(HH0), 8'h0);
      chk("cap_b0_end", 8'(B0), 8'h0);
      chk("cap_wait_rel", 8'(state0), 8'(WAIT_REL));
      BTN0 = 1'b1;
      tick(6);
      chk("cap_wait_rel_hold", 8'(state0), 8'(WAIT_REL));
      tick(1);
      chk("cap_back_idle", 8'(state0), 8'(IDLE));
      chk("cap_back_valid0", 8'(VALID0), 8'h0);

      // Glitch of 3 cycles on BTN1 must be rejected
      SW1 = 6'b11_1111; BTN1 = 1'b0;
      tick(3);
      BTN1 = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick(1);
         chk("glitch_valid1", 8'(VALID1), 8'h0);
      end

      // Re-press during HOLD restarts the window with new switches
      SW0 = 6'b10_0101; BTN0 = 1'b0;
      tick(4);
      BTN0 = 1'b1;
      tick(3);
      chk("rep_valid0", 8'(VALID0), 8'h1);
      chk("rep_hh0", 8'(HH0), 8'h5);
      SW0 = 6'b01_0011;
      tick(1);
      BTN0 = 1'b0;
      tick(6);
      chk("rep_hh0_before", 8'(HH0), 8'h5);
      tick(1);
      chk("rep_hh0_new", 8'(HH0), 8'h3);
      chk("rep_b0_new", 8'(B0), 8'h1);
      chk("rep_valid0_new", 8'(VALID0), 8'h1);
      tick(3);
      chk("rep_valid0_past_old", 8'(VALID0), 8'h1);
      tick(6);
      chk("rep_valid0_last", 8'(VALID0), 8'h1);
      tick(1);
      chk("rep_valid0_end", 8'(VALID0), 8'h0);
      chk("rep_wait_rel", 8'(state0), 8'(WAIT_REL));
      BTN0 = 1'b1;
      tick(8);
      chk("rep_idle", 8'(state0), 8'(IDLE));

      // Clear beats a coinciding press on terminal 1
      SW0 = 6'b11_1010; SW1 = 6'b01_0110; BTN0 = 1'b0; BTN1 = 1'b0;
      tick(4);
      BTN0 = 1'b1; BTN1 = 1'b1;
      tick(3);
      chk("clr_hh0", 8'(HH0), 8'hA);
      chk("clr_b0", 8'(B0), 8'h3);
      chk("clr_hh1", 8'(HH1), 8'h6);
      chk("clr_b1", 8'(B1), 8'h1);
      chk("clr_valid1", 8'(VALID1), 8'h1);
      tick(1);
      BTN1 = 1'b0; SW1 = 6'b10_1111;
      tick(4);
      BTN_CLR = 1'b0;
      tick(1);
      BTN_CLR = 1'b1;
      tick(1);
      chk("clr_valid0_pre", 8'(VALID0), 8'h1);
      chk("clr_valid1_pre", 8'(VALID1), 8'h1);
      tick(1);
      chk("clr_valid0", 8'(VALID0), 8'h0);
      chk("clr_valid1", 8'(VALID1), 8'h0);
      chk("clr_hh0_zero", 8'(HH0), 8'h0);
      chk("clr_hh1_zero", 8'(HH1), 8'h0);
      chk("clr_b1_zero", 8'(B1), 8'h0);
      tick(1);
      chk("clr_press_dropped", 8'(VALID1), 8'h0);
      chk("clr_hh1_dropped", 8'(HH1), 8'h0);
      chk("clr_state1", 8'(state1), 8'(IDLE));
      BTN1 = 1'b1;
      tick(8);
      chk("clr_after_valid1", 8'(VALID1), 8'h0);

      // Reset in the middle of HOLD
      SW0 = 6'b01_1001; BTN0 = 1'b0;
      tick(4);
      BTN0 = 1'b1;
      tick(3);
      chk("mr_valid0", 8'(VALID0), 8'h1);
      chk("mr_hh0", 8'(HH0), 8'h9);
      tick(2);
      rst_n = 1'b0;
      tick(1);
      chk("mr_valid0_rst", 8'(VALID0), 8'h0);
      chk("mr_hh0_rst", 8'(HH0), 8'h0);
      chk("mr_state0_rst", 8'(state0), 8'(IDLE));
      rst_n = 1'b1;
      tick(12);
      chk("mr_no_revalid", 8'(VALID0), 8'h0);
      BTN0 = 1'b0;
      tick(4);
      BTN0 = 1'b1;
      tick(3);
      chk("mr_fresh_valid0", 8'(VALID0), 8'h1);
      chk("mr_fresh_hh0", 8'(HH0), 8'h9);
      chk("mr_fresh_b0", 8'(B0), 8'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
